// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file: 2**ADDR_W x WIDTH register file sitting in front of the ALU.
//   Two combinational read ports, one synchronous write port. The register
//   at index ZERO_REG reads as 0 and swallows writes. With BYPASS=1, a
//   write in flight is forwarded to any read port addressing the same
//   register in the same cycle (write-first).
//
// Ports
//   clk         in   1       rising-edge clock
//   reset       in   1       synchronous active-high; clears every register
//   Read_Reg1   in   ADDR_W  read port 1 index
//   Read_Reg2   in   ADDR_W  read port 2 index
//   Write_Reg   in   ADDR_W  write port index
//   Write_Data  in   WIDTH   write data
//   Reg_Write   in   1       write enable
//   Read_Data1  out  WIDTH   contents of Read_Reg1 (ALU A)
//   Read_Data2  out  WIDTH   contents of Read_Reg2 (ALU B / store data)
// ---------------------------------------------------------------------------

// One storage entry. Reset wins over a same-edge write.
module reg_file_entry #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q, data_d;

  always_comb data_d = we_i ? d_i : data_q;

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;
endmodule

module reg_file #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Read_Reg1,
  input  logic [ADDR_W-1:0] Read_Reg2,
  input  logic [ADDR_W-1:0] Write_Reg,
  input  logic [WIDTH-1:0]  Write_Data,
  input  logic              Reg_Write,
  output logic [WIDTH-1:0]  Read_Data1,
  output logic [WIDTH-1:0]  Read_Data2
);
  localparam int                NREG   = 1 << ADDR_W;
  localparam int                NRD    = 2;
  localparam logic [ADDR_W-1:0] ZR_IDX = ADDR_W'(ZERO_REG);

  logic [NREG-1:0][WIDTH-1:0]  regs_q;
  logic [NRD-1:0][ADDR_W-1:0]  raddr;
  logic [NRD-1:0][WIDTH-1:0]   rdata;
  logic                        wr_en;

  // Writes aimed at the zero register are dropped here, so neither the
  // storage nor the bypass path ever sees them.
  assign wr_en = Reg_Write && (Write_Reg != ZR_IDX);

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_zero
      // No storage: the zero register is a constant.
      assign regs_q[g] = '0;
    end else begin : g_ent
      reg_file_entry #(.WIDTH(WIDTH)) u_ent (
        .clk   (clk),
        .reset (reset),
        .we_i  (wr_en && (Write_Reg == ADDR_W'(g))),
        .d_i   (Write_Data),
        .q_o   (regs_q[g])
      );
    end
  end

  assign raddr = {Read_Reg2, Read_Reg1};

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [WIDTH-1:0] rd;
    // Forwarding is intentionally not gated by reset: during a reset cycle
    // the port still shows the in-flight write; storage clears at the edge.
    always_comb begin
      rd = regs_q[raddr[p]];
      if ((BYPASS != 0) && wr_en && (Write_Reg == raddr[p])) rd = Write_Data;
      if (raddr[p] == ZR_IDX) rd = '0;
    end
    assign rdata[p] = rd;
  end

  assign Read_Data1 = rdata[0];
  assign Read_Data2 = rdata[1];
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: two instances (BYPASS=1 and BYPASS=0) share the same
// stimulus. A reference array of 32 registers tracks the architectural
// state; every negative edge both instances' read ports are compared with
// the value the rules say they must show. A few literal expectations pin
// the reference itself.
module tb_reg_file;
  logic        clk;
  logic        reset;
  logic [4:0]  Read_Reg1, Read_Reg2, Write_Reg;
  logic [63:0] Write_Data;
  logic        Reg_Write;
  logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;
  logic [63:0] mdl [32];

  reg_file #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
    .Write_Reg(Write_Reg), .Write_Data(Write_Data), .Reg_Write(Reg_Write),
    .Read_Data1(rd1_b), .Read_Data2(rd2_b));

  reg_file #(.WIDTH(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
    .Write_Reg(Write_Reg), .Write_Data(Write_Data), .Reg_Write(Reg_Write),
    .Read_Data1(rd1_n), .Read_Data2(rd2_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // What a read port must show this cycle, straight from the rules.
  function automatic logic [63:0] expect_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return 64'd0;
    if (byp && Reg_Write && Write_Reg == a) return Write_Data;
    return mdl[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd1_byp",   rd1_b, expect_rd(Read_Reg1, 1'b1));
      chk("rd2_byp",   rd2_b, expect_rd(Read_Reg2, 1'b1));
      chk("rd1_nobyp", rd1_n, expect_rd(Read_Reg1, 1'b0));
      chk("rd2_nobyp", rd2_n, expect_rd(Read_Reg2, 1'b0));
    end
  end

  // Commit the previous cycle's inputs at the edge, drive a new cycle,
  // then return just after the falling edge so callers can check literals.
  task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                     input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    end else if (Reg_Write && Write_Reg != 5'd31) begin
      mdl[Write_Reg] = Write_Data;
    end
    #1;
    reset = rst; Reg_Write = we; Write_Reg = wa; Write_Data = wd;
    Read_Reg1 = r1; Read_Reg2 = r2;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] d;
    logic [4:0]  wa, r1, r2;
    logic        we, rst;
    reset = 1'b1; Reg_Write = 1'b0; Write_Reg = '0; Write_Data = '0;
    Read_Reg1 = '0; Read_Reg2 = '0;
    for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    // Reset cycle with a write that must be dropped; then sweep all indices.
    cyc(1'b1, 1'b1, 5'd9, 64'hABCD, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i));
      chk("reset_sweep1", rd1_b, 64'd0);
      chk("reset_sweep2", rd2_n, 64'd0);
    end

    // X5 write then dual read.
    cyc(1'b0, 1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd5);
    chk("x5_port1", rd1_b, 64'h0123_4567_89AB_CDEF);
    chk("x5_port2", rd2_n, 64'h0123_4567_89AB_CDEF);

    // XZR write is a no-op; the sweep shows X0..X30 unchanged.
    cyc(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
    chk("xzr_byp_write", rd1_b, 64'd0);
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd5);
    chk("xzr_read", rd1_b, 64'd0);
    chk("x5_kept", rd2_b, 64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 31; i++) cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(30 - i));

    // Same-cycle forwarding vs. old value.
    cyc(1'b0, 1'b1, 5'd7, 64'h1111, 5'd0, 5'd0);
    cyc(1'b0, 1'b1, 5'd7, 64'hDEAD, 5'd7, 5'd7);
    chk("byp1_new", rd1_b, 64'hDEAD);
    chk("byp2_new", rd2_b, 64'hDEAD);
    chk("nobyp_old", rd1_n, 64'h1111);
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd7);
    chk("x7_after", rd1_n, 64'hDEAD);

    // Reset beats a same-edge write; forwarding still visible during reset.
    cyc(1'b0, 1'b1, 5'd3, 64'h10, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd4, 64'h20, 5'd4, 5'd3);
    chk("rst_byp", rd1_b, 64'h20);
    chk("rst_old_x3", rd2_n, 64'h10);
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd4);
    chk("rst_x3", rd1_b, 64'd0);
    chk("rst_x4", rd2_b, 64'd0);

    // Operands for an ALU subtract.
    cyc(1'b0, 1'b1, 5'd1, 64'h5, 5'd0, 5'd0);
    cyc(1'b0, 1'b1, 5'd2, 64'h5, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    chk("sub_eq", rd1_n - rd2_n, 64'd0);
    chk("sub_z", {63'd0, (rd1_n - rd2_n) == 64'd0}, 64'd1);
    cyc(1'b0, 1'b1, 5'd2, 64'h3, 5'd1, 5'd2);
    chk("sub_byp", rd1_b - rd2_b, 64'h2);
    cyc(1'b0, 1'b0, 5'd0, 64'd0, 5'd1, 5'd2);
    chk("sub_ne", rd1_n - rd2_n, 64'h2);
    chk("sub_nz", {63'd0, (rd1_n - rd2_n) == 64'd0}, 64'd0);

    // Random traffic; reads often collide with the write index.
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(63) == 0);
      we  = 1'($urandom_range(1));
      wa  = 5'($urandom_range(31));
      d   = {$urandom, $urandom};
      r1  = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
      r2  = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
      cyc(rst, we, wa, d, r1, r2);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
